// File: rtl/axi_tx_fifo_channel_if.sv
// Bus side of an AXI-style VALID/READY channel carrying a WIDTH-bit payload.
interface axi_tx_fifo_channel_if #(
  parameter int WIDTH = 8
);
  logic             VALID;
  logic [WIDTH-1:0] xDATA;
  logic             READY;

  modport master (output VALID, output xDATA, input READY);
  modport slave  (input VALID, input xDATA, output READY);
endinterface

// File: rtl/axi_tx_fifo_channel.sv
// TX channel: DEPTH-entry FIFO feeding a VALID/READY bus, with supply backpressure,
// flush that never disturbs a stalled presented beat, and an accepted-beat counter.
module axi_tx_fifo_channel #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi_tx_fifo_channel_if.master bus,
  input  logic [WIDTH-1:0]      tx_data,
  input  logic                  tx_en,
  output logic                  tx_hold,
  input  logic                  tx_flush,
  output logic [CW-1:0]         level,
  output logic [15:0]           beats
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_RST    = 2'd0;
  localparam logic [1:0] ST_EMPTY  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_FULL   = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [CW-1:0]    level_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push, pop, wr_en;

  // VALID comes only from registered level, so READY never reaches it combinationally.
  assign bus.VALID = (level != '0);
  assign bus.xDATA = bus.VALID ? mem[rd_ptr] : '0;
  assign tx_hold   = (state == ST_RST) || (state == ST_FULL);

  assign pop   = bus.VALID && bus.READY;
  assign push  = tx_en && !tx_hold;
  assign wr_en = push && !tx_flush;

  always_comb begin
    rd_nxt    = pop ? rd_ptr + AW'(1) : rd_ptr;
    wr_nxt    = wr_ptr;
    level_nxt = level;
    if (tx_flush) begin
      // A stalled head stays presented; everything behind it is dropped.
      if (bus.VALID && !bus.READY) begin
        wr_nxt    = rd_ptr + AW'(1);
        level_nxt = CW'(1);
      end else begin
        wr_nxt    = rd_nxt;
        level_nxt = '0;
      end
    end else begin
      if (wr_en) wr_nxt = wr_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   level_nxt = level + CW'(1);
        2'b01:   level_nxt = level - CW'(1);
        default: level_nxt = level;
      endcase
    end

    if (level_nxt == '0)            state_nxt = ST_EMPTY;
    else if (level_nxt == CW'(DEPTH)) state_nxt = ST_FULL;
    else                            state_nxt = ST_ACTIVE;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state  <= ST_RST;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      beats  <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      level  <= level_nxt;
      if (pop) beats <= beats + 16'd1;
    end
  end

  // Storage is payload only and needs no reset: nothing is presented while level is 0.
  always_ff @(posedge ACLK) begin
    if (wr_en) mem[wr_ptr] <= tx_data;
  end

  a_no_underflow: assert property (@(posedge ACLK) disable iff (!ARESETn)
    !(pop && (level == '0)));

  a_no_overflow: assert property (@(posedge ACLK) disable iff (!ARESETn)
    level <= CW'(DEPTH));

endmodule

// File: tb/tb_axi_tx_fifo_channel.sv
// Randomised plus directed bench for axi_tx_fifo_channel against a queue-based reference model.
module tb_axi_tx_fifo_channel;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             ACLK;
  logic             ARESETn;
  logic [WIDTH-1:0] tx_data;
  logic             tx_en;
  logic             tx_hold;
  logic             tx_flush;
  logic [CW-1:0]    level;
  logic [15:0]      beats;

  axi_tx_fifo_channel_if #(.WIDTH(WIDTH)) bus ();

  axi_tx_fifo_channel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .tx_hold  (tx_hold),
    .tx_flush (tx_flush),
    .level    (level),
    .beats    (beats)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: queue of beats the channel should be holding, head first.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] delivered[$];
  logic [15:0]      mbeats = '0;
  bit               rst_cycle = 1'b1;
  bit               last_push_ok = 1'b0;
  bit               stall_prev = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  bit               m_valid, m_hold;
  logic [WIDTH-1:0] head;

  // Monitor: compares DUT outputs with the model mid-cycle, then advances the model
  // by what the coming rising edge must do with the inputs now applied.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      mq.delete();
      mbeats     = '0;
      rst_cycle  = 1'b1;
      stall_prev = 1'b0;
    end
    m_valid = (mq.size() != 0);
    m_hold  = rst_cycle || (mq.size() == DEPTH);
    check("valid",   32'(bus.VALID), 32'(m_valid));
    check("xdata",   32'(bus.xDATA), m_valid ? 32'(mq[0]) : 32'd0);
    check("level",   32'(level),     32'(mq.size()));
    check("tx_hold", 32'(tx_hold),   32'(m_hold));
    check("beats",   32'(beats),     32'(mbeats));
    if (stall_prev) begin
      check("stable_valid", 32'(bus.VALID), 32'd1);
      check("stable_xdata", 32'(bus.xDATA), 32'(prev_data));
    end
    last_push_ok = 1'b0;
    if (ARESETn) begin
      stall_prev = bus.VALID && !bus.READY;
      prev_data  = bus.xDATA;
      if (bus.VALID && bus.READY) delivered.push_back(bus.xDATA);
      if (rst_cycle) begin
        rst_cycle = 1'b0;
      end else if (tx_flush) begin
        if (m_valid && !bus.READY) begin
          head = mq[0];
          mq.delete();
          mq.push_back(head);
        end else begin
          if (m_valid) mbeats = mbeats + 16'd1;
          mq.delete();
        end
      end else begin
        if (m_valid && bus.READY) begin
          void'(mq.pop_front());
          mbeats = mbeats + 16'd1;
        end
        if (tx_en && !m_hold) begin
          mq.push_back(tx_data);
          last_push_ok = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic en, input logic [WIDTH-1:0] d, input logic rdy, input logic fl);
    tx_en     = en;
    tx_data   = d;
    bus.READY = rdy;
    tx_flush  = fl;
    @(posedge ACLK);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (mq.size() != 0 && n < budget) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    check("drain_done", 32'(mq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, guard;
    ARESETn   = 1'b0;
    tx_en     = 1'b0;
    tx_data   = '0;
    tx_flush  = 1'b0;
    bus.READY = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;

    // 1: push refused in RST cycle, then single beat through
    drive(1'b1, 8'hEE, 1'b1, 1'b0);
    drive(1'b1, 8'hA1, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_beats", 32'(beats), 32'd1);
    check("t1_first", 32'(delivered.size() > 0 ? delivered[0] : 8'h00), 32'hA1);

    // 2: fill under backpressure, fifth push ignored, drain in order
    delivered.delete();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    check("t2_level", 32'(level), 32'd4);
    check("t2_hold",  32'(tx_hold), 32'd1);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_count", 32'(delivered.size()), 32'd4);
    for (int i = 0; i < 4 && i < delivered.size(); i++)
      check("t2_order", 32'(delivered[i]), 32'(8'h10 + i));
    check("t2_beats", 32'(beats), 32'd5);

    // 3: continuous supply with READY toggling; retry when held
    delivered.delete();
    idx = 0;
    guard = 0;
    while (idx < 16 && guard < 200) begin
      drive(1'b1, 8'(idx), 1'(guard % 2 == 0), 1'b0);
      if (last_push_ok) idx++;
      guard++;
    end
    check("t3_supply_done", 32'(idx), 32'd16);
    drain(20);
    check("t3_count", 32'(delivered.size()), 32'd16);
    for (int i = 0; i < 16 && i < delivered.size(); i++)
      check("t3_order", 32'(delivered[i]), 32'(i));
    check("t3_beats", 32'(beats), 32'd21);

    // 4: flush with stalled head keeps it presented, drops the rest and the push
    delivered.delete();
    drive(1'b1, 8'h20, 1'b0, 1'b0);
    drive(1'b1, 8'h21, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 8'h99, 1'b0, 1'b1);
    check("t4_level", 32'(level), 32'd1);
    check("t4_head",  32'(bus.xDATA), 32'h20);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t4_empty", 32'(level), 32'd0);
    check("t4_only",  32'(delivered.size()), 32'd1);

    // 5: full with READY=1 and tx_en=1: pop happens, push refused
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    check("t5_level", 32'(level), 32'd3);
    check("t5_hold",  32'(tx_hold), 32'd0);
    drain(10);

    // 6: async reset mid-burst
    drive(1'b1, 8'h40, 1'b0, 1'b0);
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    check("t6_pre_level", 32'(level), 32'd2);
    ARESETn = 1'b0;
    #1;
    check("t6_valid", 32'(bus.VALID), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_beats", 32'(beats), 32'd0);
    check("t6_hold",  32'(tx_hold), 32'd1);
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    check("t6_rst_refused", 32'(level), 32'd0);
    drive(1'b1, 8'h78, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_after_beats", 32'(beats), 32'd1);

    // Random traffic
    for (int i = 0; i < 500; i++)
      drive(1'($urandom_range(0, 99) < 60), 8'($urandom),
            1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 5));
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
